// File: rtl/debug_loader.sv
// debug_loader: framed host byte stream -> instruction-memory debug writes, with status bytes.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rx_valid/rx_data/rx_ready     host byte stream in (valid/ready)
//   tx_valid/tx_data/tx_ready     status byte out: 'K' ok, 'E' checksum, 'T' timeout, 'R' run
//   DEBUG_SIG                     core held in program-load mode
//   DEBUG_addr/DEBUG_instr        word-aligned write address and instruction word
//   clk_debug                     one-cycle write strobe per word
module debug_loader #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0]  SYNC_LOAD   = 8'hA5,
    parameter logic [7:0]  SYNC_RUN    = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        DEBUG_SIG,
    output logic [31:0] DEBUG_addr,
    output logic [31:0] DEBUG_instr,
    output logic        clk_debug
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {IDLE, ADDR, CNT, DATA, W_SET, W_STB, W_HLD, CSUM, RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   addr_q, addr_d, word_q, word_d;
    logic [31:0]   dbg_addr_q, dbg_addr_d, dbg_instr_q, dbg_instr_d;
    logic [15:0]   n_q, n_d;
    logic [7:0]    csum_q, csum_d, tx_data_q, tx_data_d;
    logic [TW-1:0] to_q, to_d;
    logic          tx_valid_q, tx_valid_d, dbg_sig_q, dbg_sig_d, clk_dbg_q, clk_dbg_d;
    logic          acc, in_frame, expired;

    assign rx_ready = state_q inside {IDLE, ADDR, CNT, DATA, CSUM};
    assign acc      = rx_valid & rx_ready;
    assign in_frame = state_q inside {ADDR, CNT, DATA, CSUM};
    // An accepted byte on the final count cycle wins over the timeout.
    assign expired  = in_frame && !acc && to_q == TW'(TIMEOUT_CYC - 1);

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign DEBUG_SIG   = dbg_sig_q;
    assign DEBUG_addr  = dbg_addr_q;
    assign DEBUG_instr = dbg_instr_q;
    assign clk_debug   = clk_dbg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            word_q      <= '0;
            dbg_addr_q  <= '0;
            dbg_instr_q <= '0;
            n_q         <= '0;
            csum_q      <= '0;
            tx_data_q   <= '0;
            to_q        <= '0;
            tx_valid_q  <= 1'b0;
            dbg_sig_q   <= 1'b0;
            clk_dbg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_instr_q <= dbg_instr_d;
            n_q         <= n_d;
            csum_q      <= csum_d;
            tx_data_q   <= tx_data_d;
            to_q        <= to_d;
            tx_valid_q  <= tx_valid_d;
            dbg_sig_q   <= dbg_sig_d;
            clk_dbg_q   <= clk_dbg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        word_d      = word_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_instr_d = dbg_instr_q;
        n_d         = n_q;
        csum_d      = csum_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        dbg_sig_d   = dbg_sig_q;
        // Strobe is registered: high for the cycle spent in W_HLD.
        clk_dbg_d   = state_q == W_STB;
        to_d        = acc ? '0 : in_frame ? to_q + TW'(1) : to_q;
        if (acc && state_q inside {ADDR, CNT, DATA}) begin
            csum_d = csum_q ^ rx_data;
            idx_d  = idx_q + 2'd1;
        end
        case (state_q)
            IDLE: begin
                if (acc && rx_data == SYNC_LOAD) begin
                    state_d   = ADDR;
                    dbg_sig_d = 1'b1;
                    csum_d    = '0;
                    idx_d     = '0;
                end else if (acc && rx_data == SYNC_RUN) begin
                    state_d    = RESP;
                    dbg_sig_d  = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = 8'h52;
                end
            end
            ADDR: begin
                if (acc) begin
                    addr_d  = {rx_data, addr_q[31:8]};
                    state_d = idx_q == 2'd3 ? CNT : ADDR;
                end
            end
            CNT: begin
                if (acc) begin
                    n_d = {rx_data, n_q[15:8]};
                    if (idx_q == 2'd1) begin
                        idx_d   = '0;
                        state_d = n_d != 16'd0 ? DATA : CSUM;
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    word_d  = {rx_data, word_q[31:8]};
                    state_d = idx_q == 2'd3 ? W_SET : DATA;
                end
            end
            W_SET: begin
                dbg_addr_d  = {addr_q[31:2], 2'b00};
                dbg_instr_d = word_q;
                state_d     = W_STB;
            end
            W_STB: state_d = W_HLD;
            W_HLD: begin
                addr_d  = addr_q + 32'd4;
                n_d     = n_q - 16'd1;
                state_d = n_q == 16'd1 ? CSUM : DATA;
            end
            CSUM: begin
                if (acc) begin
                    state_d    = RESP;
                    tx_valid_d = 1'b1;
                    tx_data_d  = rx_data == csum_q ? 8'h4B : 8'h45;
                end
            end
            RESP: begin
                if (tx_ready) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (expired) begin
            state_d    = RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h54;
        end
    end
endmodule

// File: tb/tb_debug_loader.sv
// tb_debug_loader: directed self-checking bench for debug_loader.
module tb_debug_loader;
    logic        clk = 1'b0, rst = 1'b1;
    logic        rx_valid = 1'b0, rx_ready, tx_valid, tx_ready = 1'b0;
    logic [7:0]  rx_data = '0, tx_data;
    logic        DEBUG_SIG, clk_debug;
    logic [31:0] DEBUG_addr, DEBUG_instr;
    int          checks = 0, errors = 0;
    logic [31:0] wa[$], wi[$];

    debug_loader #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .DEBUG_SIG(DEBUG_SIG), .DEBUG_addr(DEBUG_addr),
        .DEBUG_instr(DEBUG_instr), .clk_debug(clk_debug)
    );

    always #5 clk = ~clk;

    // Record every strobe cycle; a strobe longer than one cycle shows up as extra entries.
    always @(negedge clk) if (clk_debug) begin
        wa.push_back(DEBUG_addr);
        wi.push_back(DEBUG_instr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("rx_ready_wait", rx_ready, 1'b1);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic get_resp(input logic [7:0] code, input string tag);
        int n;
        n = 0;
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_txdata"}, {24'd0, tx_data}, {24'd0, code});
        tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
        chk({tag, "_txdrop"}, tx_valid, 1'b0);
    endtask

    // Sends a full load frame (up to two words) and checks the write timing of each word.
    task automatic frame(input logic [31:0] a, input logic [15:0] n, input logic [31:0] w0,
                         input logic [31:0] w1, input logic [7:0] cx, input string tag);
        logic [7:0]  cs;
        logic [31:0] w, ea;
        cs = 8'h00;
        ea = {a[31:2], 2'b00};
        send(8'hA5);
        chk({tag, "_sig_rise"}, DEBUG_SIG, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(a[8*i +: 8]);
            cs ^= a[8*i +: 8];
        end
        for (int i = 0; i < 2; i++) begin
            send(n[8*i +: 8]);
            cs ^= n[8*i +: 8];
        end
        for (int k = 0; k < int'(n); k++) begin
            w = k == 0 ? w0 : w1;
            for (int i = 0; i < 4; i++) begin
                send(w[8*i +: 8]);
                cs ^= w[8*i +: 8];
            end
            @(posedge clk); #1;
            chk({tag, "_e1_addr"}, DEBUG_addr, ea);
            chk({tag, "_e1_instr"}, DEBUG_instr, w);
            chk({tag, "_e1_stb"}, {rx_ready, clk_debug}, 2'b00);
            @(posedge clk); #1;
            chk({tag, "_e2_stb"}, clk_debug, 1'b1);
            @(posedge clk); #1;
            chk({tag, "_e3_stb"}, {rx_ready, clk_debug}, 2'b10);
            chk({tag, "_e3_hold"}, DEBUG_addr, ea);
            ea += 32'd4;
        end
        send(cs ^ cx);
    endtask

    initial begin
        int stable;
        #12;
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        chk("rst_sig_stb", {DEBUG_SIG, clk_debug}, 2'b00);
        chk("rst_addr", DEBUG_addr, 32'd0);
        chk("rst_instr", DEBUG_instr, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        wa.delete(); wi.delete();
        frame(32'h0000_0100, 16'd2, 32'h0000_0013, 32'h00A0_0093, 8'h00, "t1");
        get_resp(8'h4B, "t1");
        chk("t1_nwr", wa.size(), 32'd2);
        chk("t1_wr0", wa[0] ^ wi[0], 32'h0000_0100 ^ 32'h0000_0013);
        chk("t1_wr1_addr", wa[1], 32'h0000_0104);
        chk("t1_wr1_instr", wi[1], 32'h00A0_0093);
        chk("t1_sig", DEBUG_SIG, 1'b1);

        wa.delete(); wi.delete();
        frame(32'h0000_0100, 16'd2, 32'h0000_0013, 32'h00A0_0093, 8'h01, "t2");
        get_resp(8'h45, "t2");
        chk("t2_nwr", wa.size(), 32'd2);

        wa.delete(); wi.delete();
        frame(32'hFFFF_FFFE, 16'd2, 32'h1122_3344, 32'h5566_7788, 8'h00, "t3");
        get_resp(8'h4B, "t3");
        chk("t3_nwr", wa.size(), 32'd2);
        chk("t3_addr0", wa[0], 32'hFFFF_FFFC);
        chk("t3_addr1", wa[1], 32'h0000_0000);
        chk("t3_instr1", wi[1], 32'h5566_7788);

        wa.delete(); wi.delete();
        send(8'hA5);
        send(8'h00); send(8'h20); send(8'h00); send(8'h00);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
        end
        chk("t4_no_early_tx", tx_valid, 1'b0);
        @(posedge clk); #1;
        chk("t4_tx_at_16", {tx_valid, tx_data}, {1'b1, 8'h54});
        get_resp(8'h54, "t4");
        chk("t4_nwr", wa.size(), 32'd0);
        chk("t4_sig", DEBUG_SIG, 1'b1);

        frame(32'h0000_0040, 16'd0, 32'd0, 32'd0, 8'h00, "t5");
        get_resp(8'h4B, "t5");
        send(8'h5A);
        chk("t5_run", {DEBUG_SIG, tx_valid, tx_data}, {1'b0, 1'b1, 8'h52});
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_valid && tx_data == 8'h52) stable++;
        end
        chk("t5_hold", stable, 5);
        get_resp(8'h52, "t5_run");
        chk("t5_sig_low", DEBUG_SIG, 1'b0);

        wa.delete(); wi.delete();
        send(8'hA5);
        send(8'h00); send(8'h30); send(8'h00); send(8'h00);
        send(8'h01); send(8'h00);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_pre_stb", clk_debug, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_stb_drop", clk_debug, 1'b0);
        chk("t6_rst_out", {DEBUG_SIG, tx_valid, tx_data, rx_ready}, {1'b0, 1'b0, 8'h00, 1'b1});
        chk("t6_rst_bus", DEBUG_addr | DEBUG_instr, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_nwr", wa.size(), 32'd0);
        frame(32'h0000_0200, 16'd1, 32'hDEAD_BEEF, 32'd0, 8'h00, "t6b");
        get_resp(8'h4B, "t6b");
        chk("t6b_nwr", wa.size(), 32'd1);
        chk("t6b_instr", wi[0], 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/debug_loader.md
# debug_loader

Host-side program loader that drives the core's debug instruction-load port (`DEBUG_SIG`, `DEBUG_addr`, `DEBUG_instr`, `clk_debug`). It accepts a framed byte stream from a host link (UART RX or similar, valid/ready) and writes each assembled 32-bit word into instruction memory with a one-cycle `clk_debug` pulse. It reports per-frame status bytes on a transmit byte stream and controls when the core leaves debug-load mode. It sits between the host link and `core`.

## Interface
- `TIMEOUT_CYC`, 1_000_000: maximum idle cycles between bytes inside a frame before it is aborted.
- `SYNC_LOAD`, 8'hA5: byte that opens a load frame.
- `SYNC_RUN`, 8'h5A: byte that releases debug mode.
- `clk`  in  1  single clock; the loader, instruction-memory write and core all use it.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  host byte available.
- `rx_data`  in  8  host byte.
- `rx_ready`  out  1  loader accepts a byte; transfer occurs on a rising edge when `rx_valid & rx_ready`.
- `tx_valid`  out  1  status byte available.
- `tx_data`  out  8  status byte.
- `tx_ready`  in  1  host link takes the status byte.
- `DEBUG_SIG`  out  1  core held in program-load mode.
- `DEBUG_addr`  out  32  instruction-memory byte address, word aligned.
- `DEBUG_instr`  out  32  instruction word to write.
- `clk_debug`  out  1  write strobe, registered, high for exactly one cycle per word.

## Operation
- Frame layout after `SYNC_LOAD`:
  - ADDR: 4 bytes, little-endian.
  - CNT: 2 bytes, little-endian word count N, range 0..65535.
  - DATA: 4N bytes, each word little-endian.
  - CSUM: 1 byte, equal to the XOR of every byte after the sync.
- States: IDLE, ADDR, CNT, DATA, W_SET, W_STB, W_HLD, CSUM, RESP.
- IDLE:
  - `SYNC_LOAD` sets `DEBUG_SIG`=1, clears the checksum accumulator, and moves to ADDR.
  - `SYNC_RUN` clears `DEBUG_SIG` and moves to RESP with 8'h52 ('R').
  - Any other byte is discarded.
- ADDR→CNT after 4 bytes. The low 2 address bits are forced to 0.
- CNT: after 2 bytes, goes to DATA if N≠0, otherwise to CSUM.
- DATA: the 4th byte of a word goes to W_SET.
  - W_SET: `DEBUG_addr` and `DEBUG_instr` are updated.
  - W_STB: `clk_debug`=1.
  - W_HLD: `clk_debug`=0, address and data held.
  - After W_HLD, the address increments by 4 (mod 2^32, wraps silently). The state returns to DATA, or to CSUM if this was word N.
- CSUM: if the received byte equals the accumulator, RESP with 8'h4B ('K'); otherwise RESP with 8'h45 ('E'). Words already written are not rolled back.
- RESP: `tx_valid`=1 with the code held stable until `tx_ready`, then IDLE.
- `rx_ready` = 1 in IDLE/ADDR/CNT/DATA/CSUM and 0 in W_SET/W_STB/W_HLD/RESP.
- Timeout:
  - The counter clears on every accepted byte and counts only in ADDR/CNT/DATA/CSUM.
  - On reaching `TIMEOUT_CYC`-1 with no byte accepted, the frame goes to RESP with 8'h54 ('T').
  - A byte accepted on that same cycle takes priority over the timeout.
- `DEBUG_SIG` stays 1 across any number of load frames, including errored or timed-out ones, until `SYNC_RUN`.

## Timing
- Reset values:
  - State IDLE.
  - `rx_ready`=1 (combinational from state).
  - `tx_valid`=0, `tx_data`=0.
  - `DEBUG_SIG`=0, `DEBUG_addr`=0, `DEBUG_instr`=0, `clk_debug`=0.
- All outputs except `rx_ready` are registered.
- `DEBUG_SIG` rises the cycle after `SYNC_LOAD` is accepted.
- Word write: the last data byte is accepted at edge E.
  - Address and data are valid after E+1.
  - `clk_debug` is high between E+2 and E+3.
  - Address and data are held through E+3.
  - `rx_ready` returns to 1 after E+3.
  - Peak throughput is therefore 1 byte/cycle plus 3 stall cycles per word.
- Status: `tx_valid` rises the cycle after the CSUM/run byte or the timeout, and falls the cycle after the `tx_ready` handshake.
- Reset asserted mid-frame or mid-write clears everything asynchronously. A pending `clk_debug` pulse is truncated to 0 immediately; no further write is issued.

## Test plan
- Load N=2 at address 0x0000_0100 with words 0x0000_0013 and 0x00A0_0093, correct CSUM:
  - Two `clk_debug` pulses: addr 0x100/instr 0x13, then addr 0x104/instr 0x00A00093.
  - tx 8'h4B; `DEBUG_SIG` remains 1.
- Same frame with CSUM XOR 8'h01:
  - Both writes still occur; tx 8'h45.
- Start address 0xFFFF_FFFE, N=2:
  - Writes go to 0xFFFF_FFFC, then 0x0000_0000.
- Address bytes only, then silence with `TIMEOUT_CYC`=16:
  - tx 8'h54 exactly 16 cycles after the last byte; no `clk_debug` pulse; `DEBUG_SIG`=1.
- N=0 frame, then `SYNC_RUN` with `tx_ready` held low 5 cycles:
  - tx 8'h4B, then 8'h52 held stable for 5 cycles; `DEBUG_SIG`=0 after the run byte.
- Assert `rst` on the cycle `clk_debug`=1:
  - `clk_debug` drops immediately; all outputs at reset values.
  - The next frame loads correctly.
